// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter and its future receiver:
// FSM state encoding, line-level constants and a counter-width helper.
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last clock of each line bit. Held at 0 while disabled.
module serial_frame_tx_bit_timer
  import serial_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned     CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end = en && (cnt_q == LAST);

  // Next count: restart at every bit end, hold at zero when idle.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d -- no latch.
    cnt_d = cnt_q;
    if (!en || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) for flops; blocking (=) only in always_comb.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter. Accepts a word over valid/ready
// and sends start bit, data LSB-first, optional even parity, stop bit, each
// bit held for CLKS_PER_BIT clocks. All outputs are registered.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   IW       = cnt_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [IW-1:0]    idx_q,       idx_d;
  logic             parity_q,    parity_d;
  logic             txd_q,       txd_d;
  logic             din_ready_q, din_ready_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             bit_end;

  serial_frame_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  // Frame sequencing: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    txd_d       = txd_q;
    din_ready_d = din_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (din_valid && din_ready_q) begin
          shreg_d     = din;
          parity_d    = ^din;
          idx_d       = '0;
          state_d     = START;
          txd_d       = START_BIT;
          busy_d      = 1'b1;
          din_ready_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = STOP;
              txd_d   = STOP_BIT;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_d[0];
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = STOP_BIT;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d     = IDLE;
          txd_d       = LINE_IDLE;
          busy_d      = 1'b0;
          din_ready_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        txd_d       = LINE_IDLE;
        busy_d      = 1'b0;
        din_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      parity_q    <= 1'b0;
      txd_q       <= LINE_IDLE;
      din_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      txd_q       <= txd_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign txd       = txd_q;
  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx. Instance a uses the defaults (8 bits, 4
// clocks/bit, parity); instance b drops the parity bit. Drivers push each
// accepted word into a per-instance queue; monitors pop it when a frame
// appears on the line and compare every line clock against the frame model.
module tb_serial_frame_tx;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_a, din_b;
  logic         valid_a, valid_b;
  logic         ready_a, ready_b;
  logic         txd_a, txd_b;
  logic         busy_a, busy_b;
  logic         done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  int           starts_a[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(1)) u_dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a),
    .din_ready(ready_a), .txd(txd_a), .busy(busy_a), .done(done_a)
  );

  serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(0)) u_dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b),
    .din_ready(ready_b), .txd(txd_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line value of bit slot `slot` of a frame carrying word w.
  function automatic logic frame_bit(input logic [W-1:0] w, input int par_en, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= W) return w[slot-1];
    if (par_en != 0 && slot == W + 1) return logic'($countones(w) % 2);
    return 1'b1;
  endfunction

  // {txd, busy, din_ready, done} of instance i.
  function automatic logic [3:0] stat(input int i);
    return (i != 0) ? {txd_b, busy_b, ready_b, done_b} : {txd_a, busy_a, ready_a, done_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer word w on instance i; returns 2ns after the accepting edge.
  task automatic send(input int i, input logic [W-1:0] w, input bit keep_valid);
    int t = 0;
    if (i != 0) begin din_b = w; valid_b = 1'b1; end
    else        begin din_a = w; valid_a = 1'b1; end
    while (((i != 0) ? ready_b : ready_a) !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check("handshake_wait_bound", 32'(t < 200), 32'd1);
    if (i != 0) q_b.push_back(w);
    else        q_a.push_back(w);
    tick();
    if (!keep_valid) begin
      if (i != 0) valid_b = 1'b0;
      else        valid_a = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(q_a.size() == 0 && q_b.size() == 0 && !busy_a && !busy_b) && t < 5000) begin
      tick();
      t++;
    end
    check("idle_wait_bound", 32'(t < 5000), 32'd1);
    tick();
    tick();
  endtask

  // Frame monitor for instance i, sampling on falling edges.
  task automatic monitor(input int i);
    int           par;
    int           nclk;
    logic [W-1:0] w;
    logic [3:0]   st;
    bit           aborted;
    bit           have;
    par  = (i != 0) ? 0 : 1;
    nclk = (2 + W + par) * C;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      st = stat(i);
      if (st[2] !== 1'b1) begin
        check("idle_outputs", 32'(st), 32'b1010);
        continue;
      end
      have = ((i != 0) ? q_b.size() : q_a.size()) > 0;
      check("frame_has_pending_word", 32'(have), 32'd1);
      w = '0;
      if (have) w = (i != 0) ? q_b.pop_front() : q_a.pop_front();
      if (i == 0) starts_a.push_back(cyc);
      aborted = 1'b0;
      for (int k = 0; k < nclk; k++) begin
        if (k > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        st = stat(i);
        check("txd_bit", 32'(st[3]), 32'(frame_bit(w, par, k / C)));
        check("busy_status", 32'(st[2:0]), 32'b100);
      end
      @(negedge clk);
      st = stat(i);
      if (aborted) check("reset_abort_outputs", 32'(st), 32'b1010);
      else         check("frame_end_outputs", 32'(st), 32'b1011);
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] st;
    int         gap;

    // Reset with din_valid asserted: nothing may be accepted.
    rst = 1'b1; din_a = 8'hFF; din_b = 8'hFF; valid_a = 1'b1; valid_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    st = stat(0);
    check("reset_state_a", 32'(st), 32'b1010);
    st = stat(1);
    check("reset_state_b", 32'(st), 32'b1010);
    tick();
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (3) tick();

    // Single frames, including an odd-weight word on both parity settings.
    send(0, 8'hA5, 1'b0);
    wait_idle();
    send(0, 8'h01, 1'b0);
    send(1, 8'h01, 1'b0);
    wait_idle();

    // Back-to-back with din_valid held high.
    send(0, 8'h3C, 1'b1);
    send(0, 8'hC3, 1'b0);
    wait_idle();
    gap = starts_a[starts_a.size()-1] - starts_a[starts_a.size()-2];
    check("back_to_back_period", 32'(gap), 32'((2 + W + 1) * C + 1));

    // din changes and din_valid pulses mid-frame are ignored.
    send(0, 8'h96, 1'b0);
    repeat (10) tick();
    din_a = 8'h00; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; din_a = 8'hFF;
    repeat (5) tick();
    din_a = 8'h5A;
    wait_idle();

    // Reset during DATA bit 3, then a clean 0xFF frame.
    send(0, 8'h6B, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    rst = 1'b1;
    q_a.delete();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    send(0, 8'hFF, 1'b0);
    wait_idle();

    // Randomized traffic on both instances.
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(0, W'($urandom), 1'($urandom_range(0, 1)));
        end
        valid_a = 1'b0;
      end
      begin
        for (int n = 0; n < 8; n++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(1, W'($urandom), 1'($urandom_range(0, 1)));
        end
        valid_b = 1'b0;
      end
    join
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-in, serial-out frame transmitter. It is the transmit end of the team's serial capture chain, whose receiving end samples a line with flip-flops.
Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single line. Frame order: start bit, data LSB-first, optional even parity, stop bit.
Each bit is held for CLKS_PER_BIT clocks. Used wherever a register value must be shipped to a downstream serial receiver.

Parameters:
WIDTH, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clocks each line bit is held (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after the data; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock, single domain
rst  input  1  synchronous, active-high reset
din  input  WIDTH  word to transmit; sampled only on acceptance
din_valid  input  1  producer has a word on din
din_ready  output  1  block can accept a word (registered)
txd  output  1  serial line (registered); idles high
busy  output  1  frame in progress (registered)
done  output  1  one-cycle pulse when a frame completes (registered)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values (rst high at a rising edge): txd=1, din_ready=1, busy=0, done=0, state=IDLE, all counters 0. rst overrides everything, including mid-frame; there is no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: occurs at an edge where din_valid & din_ready are both 1. At that edge:
  - the shift register loads din;
  - the parity bit is registered as the XOR of din;
  - state moves to START; txd<=0, busy<=1, din_ready<=0.
- din_valid while din_ready=0 is ignored; din is not sampled.
- Bit timing: a bit counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. Each state holds txd for exactly CLKS_PER_BIT clocks. Advance happens at the edge where the counter equals CLKS_PER_BIT-1.
- START: txd=0 → DATA, txd<=shreg[0].
- DATA: at each bit end, shift right and increment the bit index. After bit WIDTH-1:
  - go to PARITY if PARITY_EN=1, with txd<=parity;
  - otherwise go to STOP, with txd<=1.
- PARITY: → STOP, txd<=1.
- STOP: at its end → IDLE. At that edge: busy<=0, din_ready<=1, done<=1 for exactly one cycle, txd stays 1.
- Frame length: (2+WIDTH+PARITY_EN)*CLKS_PER_BIT clocks from the acceptance edge to the IDLE-return edge.
- Back-to-back: a new word is accepted at the earliest one edge after the IDLE return. The line therefore shows exactly one idle-high clock between frames. Frame period under continuous din_valid is (2+WIDTH+PARITY_EN)*CLKS_PER_BIT+1 clocks.
- CLKS_PER_BIT=1: the bit counter is constant 0, so every state lasts one clock.
- Counter widths: bit counter $clog2(CLKS_PER_BIT), min 1 bit. Data index $clog2(WIDTH), min 1 bit. No wrap other than the defined reset-to-0 at each bit end.
- done and din_ready are asserted in the same cycle. busy is the inverse of din_ready at all times.

Decomposition:
- Shared package/header holds:
  - the state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - line-level constants (LINE_IDLE=1, START_BIT=0, STOP_BIT=1).
  The future receiver reuses them.
- One natural sub-module: bit_timer. It is the CLKS_PER_BIT counter with clk, rst and an enable input, and a bit_end output. The FSM, shift register and parity stay in the top module.

Test Plan:
1. Reset: hold rst 3 cycles with din_valid=1 → txd=1, din_ready=1, busy=0, done=0; nothing accepted.
2. Single frame, defaults, din=0xA5 → txd holds 4 clocks each of: 0,1,0,1,0,0,1,0,1,0(parity),1. busy for 44 clocks; done pulses 1 cycle at clock 44; din_ready returns 1 at the same edge.
3. Parity odd-count word: din=0x01 → data bits 1,0,0,0,0,0,0,0 and parity bit 1. With PARITY_EN=0 the same word gives a 40-clock frame with no parity bit.
4. Back-to-back: din_valid held high with 0x3C then 0xC3 → frames start 45 clocks apart; exactly one txd=1 idle clock between stop bit and next start bit; both words serialized correctly.
5. Ignored input: during a frame change din and pulse din_valid → transmitted bits unchanged; no extra acceptance.
6. Reset mid-frame: assert rst during DATA bit 3 → next edge txd=1, busy=0, din_ready=1, no done pulse. A following 0xFF frame is sent cleanly.
